piece_dispenser: RTL and testbench
==================================

Name: piece_dispenser

Overview:
- Consumer end of the next-piece queue produced by the seven-bag generator.
- Pops the queue head on demand from the game FSM and presents it as the active piece.
- Drives the spawn handshake and implements the once-per-piece hold slot (swap, or stash-and-fetch).
- Sits between the seven-bag queue output and the game FSM/playfield logic.

Parameters:
- CNT_W, 16, width of the dispensed-piece counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  clock.
- rst_l  input  1  asynchronous, active-low reset.
- game_clear  input  1  synchronous clear to the reset state at game start.
- new_piece_req  input  1  one-cycle pulse from the game FSM after a lock; request the next piece.
- hold_req  input  1  one-cycle pulse from the player hold input.
- queue_head  input  $bits(tile_type_t)  front of the next-piece queue (index 0); BLANK means not yet filled.
- pieces_remove  output  1  pop strobe to the seven-bag queue.
- active_piece  output  tile_type_t  current falling piece.
- active_valid  output  1  active_piece is in play.
- spawn_pulse  output  1  one-cycle strobe; the playfield places active_piece at the spawn origin.
- hold_piece  output  tile_type_t  hold slot contents; BLANK when empty.
- hold_used  output  1  hold already used for the current piece.
- pieces_dispensed  output  CNT_W  count of pops issued.

Behaviour:
- Reset (rst_l low) or game_clear:
  - state = IDLE; active_piece = BLANK; hold_piece = BLANK.
  - active_valid = 0; hold_used = 0; pieces_remove = 0; spawn_pulse = 0; pieces_dispensed = 0.
  - game_clear has priority over every other input.
- FSM states: IDLE, FETCH, SPAWN, ACTIVE. The state register is the only reset-to-IDLE element.
- IDLE:
  - new_piece_req -> FETCH.
  - hold_req is ignored.
- FETCH:
  - If queue_head != BLANK: pieces_remove = 1 combinationally this cycle; active_piece <= queue_head; pieces_dispensed += 1; -> SPAWN.
  - If queue_head == BLANK: stall in FETCH with pieces_remove = 0.
  - pieces_remove is therefore high for exactly one cycle per pop and never when the head is BLANK.
  - new_piece_req and hold_req are ignored.
- SPAWN:
  - spawn_pulse = 1 for exactly one cycle; active_valid = 1 from this cycle.
  - -> ACTIVE unconditionally. Inputs are ignored.
- ACTIVE:
  - new_piece_req (highest priority; a coincident hold_req is dropped): hold_used <= 0; active_valid <= 0; -> FETCH.
  - hold_req with hold_used == 1: ignored; no state change.
  - hold_req with hold_used == 0 and hold_piece == BLANK: hold_piece <= active_piece; hold_used <= 1; active_valid <= 0; -> FETCH.
  - hold_req with hold_used == 0 and hold_piece != BLANK: swap active_piece and hold_piece in one edge; hold_used <= 1; active_valid stays 1; -> SPAWN. No pop is issued.
- hold_used changes only as follows:
  - Set only by an accepted hold.
  - Cleared only by new_piece_req accepted in ACTIVE, or by reset/clear.
  - It stays 1 through a hold-initiated FETCH/SPAWN.
- Latency:
  - new_piece_req at cycle n with a non-BLANK head gives pieces_remove at n+1, spawn_pulse at n+2, ACTIVE at n+3.
  - Hold swap at cycle n gives spawn_pulse at n+1.
- Reset mid-FETCH asserted in the same cycle as pieces_remove: the asynchronous reset wins. No partial state is kept and the counter is 0. The bag side resets concurrently.
- pieces_dispensed wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- GamePkg: dispenser_state_t enum {IDLE, FETCH, SPAWN, ACTIVE}; SPAWN_LATENCY = 2 constant for benches.
- DisplayPkg: existing tile_type_t, including BLANK.
- No sub-module. The active/hold/counter registers use the existing register module or inline flops; the FSM lives inline.

Test Plan:
- Reset, then queue_head = T, new_piece_req at cycle 0 -> pieces_remove at 1, spawn_pulse at 2, active_piece = T, active_valid = 1, pieces_dispensed = 1.
- queue_head = BLANK for 5 cycles after new_piece_req, then O -> stays in FETCH, no pieces_remove while BLANK; single pieces_remove the cycle O appears; active_piece = O.
- Active I, hold empty, head = Z, hold_req -> hold_piece = I, hold_used = 1, pop, active_piece = Z, spawn_pulse; a second hold_req is ignored (active remains Z).
- Active S with hold = L after a new_piece_req clears hold_used; hold_req -> active_piece = L, hold_piece = S, spawn_pulse one cycle later, no pieces_remove, pieces_dispensed unchanged.
- new_piece_req and hold_req in the same ACTIVE cycle -> hold_piece unchanged, hold_used = 0, normal fetch.
- CNT_W = 3, 9 dispenses -> pieces_dispensed = 1. game_clear mid-ACTIVE -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/piece_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piece_dispenser_pkg
// Description : Shared tile encoding and dispenser FSM state constants.
// Revision    : 1.0 - initial release
// ============================================================================
package piece_dispenser_pkg;

    typedef enum logic [2:0] {
        BLANK  = 3'd0,
        TILE_I = 3'd1,
        TILE_O = 3'd2,
        TILE_T = 3'd3,
        TILE_S = 3'd4,
        TILE_Z = 3'd5,
        TILE_J = 3'd6,
        TILE_L = 3'd7
    } tile_type_t;

    typedef logic [1:0] dispenser_state_t;

    localparam dispenser_state_t c_st_idle   = 2'd0;
    localparam dispenser_state_t c_st_fetch  = 2'd1;
    localparam dispenser_state_t c_st_spawn  = 2'd2;
    localparam dispenser_state_t c_st_active = 2'd3;

    // Cycles from a piece request to its spawn strobe.
    localparam int c_spawn_latency = 2;

    function automatic logic tile_present(input tile_type_t tile);
        return tile != BLANK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : piece_dispenser
// Description : Pops the next-piece queue, drives spawn, and owns the hold slot.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_dispenser
    import piece_dispenser_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             game_clear,
    input  logic             new_piece_req,
    input  logic             hold_req,
    input  tile_type_t       queue_head,
    output logic             pieces_remove,
    output tile_type_t       active_piece,
    output logic             active_valid,
    output logic             spawn_pulse,
    output tile_type_t       hold_piece,
    output logic             hold_used,
    output logic [CNT_W-1:0] pieces_dispensed
);

    dispenser_state_t r_state;
    dispenser_state_t w_state_nxt;
    tile_type_t       r_active;
    tile_type_t       w_active_nxt;
    tile_type_t       r_hold;
    tile_type_t       w_hold_nxt;
    logic             r_hold_used;
    logic             w_hold_used_nxt;
    logic             r_active_valid;
    logic             w_active_valid_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_pop;

    assign w_pop = (r_state == c_st_fetch) && tile_present(queue_head);

    always_comb begin
        w_state_nxt        = r_state;
        w_active_nxt       = r_active;
        w_hold_nxt         = r_hold;
        w_hold_used_nxt    = r_hold_used;
        w_active_valid_nxt = r_active_valid;
        w_count_nxt        = r_count;

        case (r_state)
            c_st_idle: begin
                if (new_piece_req) begin
                    w_state_nxt = c_st_fetch;
                end
            end

            c_st_fetch: begin
                // A BLANK head means the bag has not refilled yet; wait for it.
                if (w_pop) begin
                    w_active_nxt       = queue_head;
                    w_count_nxt        = r_count + CNT_W'(1);
                    w_active_valid_nxt = 1'b1;
                    w_state_nxt        = c_st_spawn;
                end
            end

            c_st_spawn: begin
                w_state_nxt = c_st_active;
            end

            c_st_active: begin
                if (new_piece_req) begin
                    w_hold_used_nxt    = 1'b0;
                    w_active_valid_nxt = 1'b0;
                    w_state_nxt        = c_st_fetch;
                end else if (hold_req && !r_hold_used) begin
                    w_hold_used_nxt = 1'b1;
                    w_hold_nxt      = r_active;
                    if (!tile_present(r_hold)) begin
                        // Empty slot: stash the piece and fetch a fresh one.
                        w_active_valid_nxt = 1'b0;
                        w_state_nxt        = c_st_fetch;
                    end else begin
                        w_active_nxt = r_hold;
                        w_state_nxt  = c_st_spawn;
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state        <= c_st_idle;
            r_active       <= BLANK;
            r_hold         <= BLANK;
            r_hold_used    <= 1'b0;
            r_active_valid <= 1'b0;
            r_count        <= '0;
        end else if (game_clear) begin
            r_state        <= c_st_idle;
            r_active       <= BLANK;
            r_hold         <= BLANK;
            r_hold_used    <= 1'b0;
            r_active_valid <= 1'b0;
            r_count        <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_active       <= w_active_nxt;
            r_hold         <= w_hold_nxt;
            r_hold_used    <= w_hold_used_nxt;
            r_active_valid <= w_active_valid_nxt;
            r_count        <= w_count_nxt;
        end
    end

    // Strobes are suppressed while a clear is pending so the bag never sees a stray pop.
    assign pieces_remove    = w_pop && !game_clear;
    assign spawn_pulse      = (r_state == c_st_spawn) && !game_clear;
    assign active_piece     = r_active;
    assign active_valid     = r_active_valid;
    assign hold_piece       = r_hold;
    assign hold_used        = r_hold_used;
    assign pieces_dispensed = r_count;

endmodule
`default_nettype wire

// File: tb/tb_piece_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_piece_dispenser
// Description : Self-checking bench for piece_dispenser with a flag-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piece_dispenser;
    import piece_dispenser_pkg::*;

    localparam int TB_CNT_W = 3;

    logic                clk = 1'b0;
    logic                rst_l = 1'b0;
    logic                game_clear = 1'b0;
    logic                new_piece_req = 1'b0;
    logic                hold_req = 1'b0;
    tile_type_t          queue_head = BLANK;
    logic                pieces_remove;
    tile_type_t          active_piece;
    logic                active_valid;
    logic                spawn_pulse;
    tile_type_t          hold_piece;
    logic                hold_used;
    logic [TB_CNT_W-1:0] pieces_dispensed;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    piece_dispenser #(.CNT_W(TB_CNT_W)) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .game_clear       (game_clear),
        .new_piece_req    (new_piece_req),
        .hold_req         (hold_req),
        .queue_head       (queue_head),
        .pieces_remove    (pieces_remove),
        .active_piece     (active_piece),
        .active_valid     (active_valid),
        .spawn_pulse      (spawn_pulse),
        .hold_piece       (hold_piece),
        .hold_used        (hold_used),
        .pieces_dispensed (pieces_dispensed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a piece is either being fetched, awaiting its spawn strobe, or live.
    bit         m_fetching  = 1'b0;
    bit         m_spawn_due = 1'b0;
    bit         m_live      = 1'b0;
    bit         m_valid     = 1'b0;
    bit         m_used      = 1'b0;
    tile_type_t m_active    = BLANK;
    tile_type_t m_hold      = BLANK;
    int         m_count     = 0;

    task automatic model_reset();
        m_fetching  = 1'b0;
        m_spawn_due = 1'b0;
        m_live      = 1'b0;
        m_valid     = 1'b0;
        m_used      = 1'b0;
        m_active    = BLANK;
        m_hold      = BLANK;
        m_count     = 0;
    endtask

    always @(posedge clk or negedge rst_l) begin
        tile_type_t tmp;
        if (!rst_l || game_clear) begin
            model_reset();
        end else if (m_spawn_due) begin
            m_spawn_due = 1'b0;
            m_live      = 1'b1;
        end else if (m_fetching) begin
            if (queue_head != BLANK) begin
                m_active    = queue_head;
                m_count     = m_count + 1;
                m_fetching  = 1'b0;
                m_spawn_due = 1'b1;
                m_valid     = 1'b1;
            end
        end else if (m_live) begin
            if (new_piece_req) begin
                m_live     = 1'b0;
                m_fetching = 1'b1;
                m_used     = 1'b0;
                m_valid    = 1'b0;
            end else if (hold_req && !m_used) begin
                m_used = 1'b1;
                m_live = 1'b0;
                if (m_hold == BLANK) begin
                    m_hold     = m_active;
                    m_fetching = 1'b1;
                    m_valid    = 1'b0;
                end else begin
                    tmp         = m_hold;
                    m_hold      = m_active;
                    m_active    = tmp;
                    m_spawn_due = 1'b1;
                end
            end
        end else if (new_piece_req) begin
            m_fetching = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc pieces_remove", 32'(pieces_remove),
                  32'(m_fetching && queue_head != BLANK && !game_clear));
            check("cyc spawn_pulse", 32'(spawn_pulse), 32'(m_spawn_due && !game_clear));
            check("cyc active_piece", 32'(active_piece), 32'(m_active));
            check("cyc active_valid", 32'(active_valid), 32'(m_valid));
            check("cyc hold_piece", 32'(hold_piece), 32'(m_hold));
            check("cyc hold_used", 32'(hold_used), 32'(m_used));
            check("cyc pieces_dispensed", 32'(pieces_dispensed),
                  32'(m_count % (1 << TB_CNT_W)));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic request(input tile_type_t head);
        queue_head    = head;
        new_piece_req = 1'b1;
        step(1);
        new_piece_req = 1'b0;
    endtask

    task automatic clear_game();
        game_clear = 1'b1;
        step(1);
        game_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(2);
        started = 1'b1;
        check("reset active_piece", 32'(active_piece), 32'(BLANK));
        check("reset hold_piece", 32'(hold_piece), 32'(BLANK));
        check("reset count", 32'(pieces_dispensed), 0);
        rst_l = 1'b1;
        step(1);

        // Basic fetch of T: pop one cycle after request, spawn the next.
        request(TILE_T);
        check("fetch pieces_remove", 32'(pieces_remove), 1);
        step(1);
        check("fetch spawn_pulse", 32'(spawn_pulse), 1);
        check("fetch active_piece", 32'(active_piece), 32'(TILE_T));
        check("fetch active_valid", 32'(active_valid), 1);
        check("fetch count", 32'(pieces_dispensed), 1);
        step(1);

        // BLANK head stalls the fetch.
        request(BLANK);
        for (int i = 0; i < 5; i++) begin
            check("stall pieces_remove", 32'(pieces_remove), 0);
            step(1);
        end
        queue_head = TILE_O;
        #1;
        check("stall release pop", 32'(pieces_remove), 1);
        step(1);
        check("stall active_piece", 32'(active_piece), 32'(TILE_O));
        step(1);

        // Clear mid-ACTIVE.
        clear_game();
        check("clear active_valid", 32'(active_valid), 0);
        check("clear count", 32'(pieces_dispensed), 0);
        check("clear active_piece", 32'(active_piece), 32'(BLANK));

        // Stash-and-fetch hold, then a second hold is ignored.
        request(TILE_I);
        step(2);
        queue_head = TILE_Z;
        hold_req   = 1'b1;
        step(1);
        hold_req = 1'b0;
        check("stash hold_piece", 32'(hold_piece), 32'(TILE_I));
        check("stash hold_used", 32'(hold_used), 1);
        check("stash pop", 32'(pieces_remove), 1);
        step(1);
        check("stash active_piece", 32'(active_piece), 32'(TILE_Z));
        check("stash spawn_pulse", 32'(spawn_pulse), 1);
        step(1);
        hold_req = 1'b1;
        step(1);
        hold_req = 1'b0;
        check("rehold active_piece", 32'(active_piece), 32'(TILE_Z));
        check("rehold spawn_pulse", 32'(spawn_pulse), 0);
        step(1);

        // Swap: hold = L, active = S after a fresh request.
        clear_game();
        request(TILE_L);
        step(2);
        queue_head = TILE_S;
        hold_req   = 1'b1;
        step(1);
        hold_req = 1'b0;
        step(2);
        request(TILE_S);
        step(2);
        check("preswap hold_used", 32'(hold_used), 0);
        check("preswap count", 32'(pieces_dispensed), 3);
        hold_req = 1'b1;
        step(1);
        hold_req = 1'b0;
        check("swap spawn_pulse", 32'(spawn_pulse), 1);
        check("swap active_piece", 32'(active_piece), 32'(TILE_L));
        check("swap hold_piece", 32'(hold_piece), 32'(TILE_S));
        check("swap pieces_remove", 32'(pieces_remove), 0);
        check("swap count", 32'(pieces_dispensed), 3);
        step(1);

        // Request and hold together: request wins.
        request(TILE_T);
        step(2);
        queue_head    = TILE_J;
        new_piece_req = 1'b1;
        hold_req      = 1'b1;
        step(1);
        new_piece_req = 1'b0;
        hold_req      = 1'b0;
        check("coinc hold_piece", 32'(hold_piece), 32'(TILE_S));
        check("coinc hold_used", 32'(hold_used), 0);
        check("coinc pop", 32'(pieces_remove), 1);
        step(1);
        check("coinc active_piece", 32'(active_piece), 32'(TILE_J));
        step(1);

        // Counter wraps modulo 8.
        clear_game();
        for (int i = 0; i < 9; i++) begin
            request(TILE_J);
            step(2);
        end
        check("wrap count", 32'(pieces_dispensed), 1);

        // Async reset in the same cycle as a pop.
        request(TILE_T);
        check("prereset pop", 32'(pieces_remove), 1);
        rst_l = 1'b0;
        #1;
        check("async count", 32'(pieces_dispensed), 0);
        check("async pop", 32'(pieces_remove), 0);
        check("async active_piece", 32'(active_piece), 32'(BLANK));
        step(2);
        rst_l = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
